// File: rtl/wire_router.sv
// wire_router: registered, run-time programmable N_IN -> N_OUT channel router.
//
// Each output channel j is driven, one cycle later, by the input channel that
// active[j] selects. The routing table is written into a shadow copy through a
// valid/ready port and swapped into the active table on commit. After a commit,
// the port is busy for one cycle.
//
// Optional feature macro: WIRE_ROUTER_INV_EN adds a per-entry invert bit and
// the cfg_inv input.
//
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset
//   din        - N_IN channels, channel i at din[i*DW +: DW]
//   dout       - N_OUT channels, channel j at dout[j*DW +: DW], registered
//   cfg_valid  - table write request (shadow[cfg_idx] <= cfg_sel)
//   cfg_idx    - output channel to program
//   cfg_sel    - input channel to route to cfg_idx
//   cfg_inv    - invert bit for the entry (WIRE_ROUTER_INV_EN only)
//   cfg_commit - copy the shadow table into the active table
//   cfg_ready  - port accepts cfg_valid/cfg_commit this cycle
//   cfg_err    - one-cycle pulse after an out-of-range write is rejected
//   map_ver    - number of completed commits, wraps at 256
module wire_router #(
  parameter int unsigned N_IN  = 3,
  parameter int unsigned N_OUT = 4,
  parameter int unsigned DW    = 1,
  parameter int unsigned SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int unsigned IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN*DW-1:0]    din,
  output logic [N_OUT*DW-1:0]   dout,
  input  logic                  cfg_valid,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [SEL_W-1:0]      cfg_sel,
`ifdef WIRE_ROUTER_INV_EN
  input  logic                  cfg_inv,
`endif
  input  logic                  cfg_commit,
  output logic                  cfg_ready,
  output logic                  cfg_err,
  output logic [7:0]            map_ver
);

  typedef logic [N_OUT-1:0][SEL_W-1:0] map_t;
  typedef enum logic {StIdle, StSwap} state_e;

  // Spreads the outputs evenly over the inputs; for 3 -> 4 this is 0,1,1,2.
  function automatic map_t def_map();
    map_t m;
    for (int unsigned j = 0; j < N_OUT; j++) begin
      if (N_OUT == 1) begin
        m[j] = '0;
      end else begin
        m[j] = SEL_W'((j * (N_IN - 1) + (N_OUT - 1) / 2) / ((N_OUT > 1) ? (N_OUT - 1) : 1));
      end
    end
    return m;
  endfunction

  localparam map_t DefMap = def_map();

  state_e               state_q, state_d;
  map_t                 active_q, active_d;
  map_t                 shadow_q, shadow_d;
  logic [N_OUT*DW-1:0]  dout_q, dout_d;
  logic [7:0]           ver_q, ver_d;
  logic                 err_q, err_d;
  logic                 wr_fire, wr_ok, commit_fire;
`ifdef WIRE_ROUTER_INV_EN
  logic [N_OUT-1:0]     active_inv_q, active_inv_d;
  logic [N_OUT-1:0]     shadow_inv_q, shadow_inv_d;
`endif

  // Control: write into shadow, commit into active, one busy cycle after commit.
  always_comb begin
    cfg_ready   = (state_q == StIdle);
    wr_fire     = cfg_valid && cfg_ready;
    wr_ok       = wr_fire && (32'(cfg_sel) < N_IN) && (32'(cfg_idx) < N_OUT);
    commit_fire = cfg_commit && cfg_ready;
    err_d       = wr_fire && !wr_ok;

    shadow_d = shadow_q;
`ifdef WIRE_ROUTER_INV_EN
    shadow_inv_d = shadow_inv_q;
`endif
    for (int unsigned j = 0; j < N_OUT; j++) begin
      if (wr_ok && (32'(cfg_idx) == j)) begin
        shadow_d[j] = cfg_sel;
`ifdef WIRE_ROUTER_INV_EN
        shadow_inv_d[j] = cfg_inv;
`endif
      end
    end

    // A write in the commit cycle is folded into the committed table.
    active_d = commit_fire ? shadow_d : active_q;
`ifdef WIRE_ROUTER_INV_EN
    active_inv_d = commit_fire ? shadow_inv_d : active_inv_q;
`endif
    ver_d   = commit_fire ? ver_q + 8'd1 : ver_q;
    state_d = commit_fire ? StSwap : StIdle;
  end

  // Datapath uses the table in effect before this edge.
  always_comb begin
    dout_d = '0;
    for (int unsigned j = 0; j < N_OUT; j++) begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        if (32'(active_q[j]) == i) begin
          dout_d[j*DW +: DW] = din[i*DW +: DW];
        end
      end
`ifdef WIRE_ROUTER_INV_EN
      if (active_inv_q[j]) begin
        dout_d[j*DW +: DW] = ~dout_d[j*DW +: DW];
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      active_q <= DefMap;
      shadow_q <= DefMap;
      dout_q   <= '0;
      ver_q    <= '0;
      err_q    <= 1'b0;
`ifdef WIRE_ROUTER_INV_EN
      active_inv_q <= '0;
      shadow_inv_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      ver_q    <= ver_d;
      err_q    <= err_d;
`ifdef WIRE_ROUTER_INV_EN
      active_inv_q <= active_inv_d;
      shadow_inv_q <= shadow_inv_d;
`endif
    end
  end

  assign dout    = dout_q;
  assign map_ver = ver_q;
  assign cfg_err = err_q;

endmodule

// File: tb/tb_wire_router.sv
module tb_wire_router;
  localparam int N_IN  = 3;
  localparam int N_OUT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] din = '0;
  logic [3:0] dout;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_idx = '0;
  logic [1:0] cfg_sel = '0;
  logic       cfg_commit = 1'b0;
  logic       cfg_ready, cfg_err;
  logic [7:0] map_ver;
`ifdef WIRE_ROUTER_INV_EN
  logic       cfg_inv = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state: tables as plain integer arrays.
  int         m_act[N_OUT];
  int         m_shd[N_OUT];
  bit         m_act_inv[N_OUT];
  bit         m_shd_inv[N_OUT];
  int         m_ver;
  bit         m_busy;
  bit         m_err;
  logic [3:0] m_dout;

  always #5 clk = ~clk;

  wire_router dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .dout       (dout),
    .cfg_valid  (cfg_valid),
    .cfg_idx    (cfg_idx),
    .cfg_sel    (cfg_sel),
`ifdef WIRE_ROUTER_INV_EN
    .cfg_inv    (cfg_inv),
`endif
    .cfg_commit (cfg_commit),
    .cfg_ready  (cfg_ready),
    .cfg_err    (cfg_err),
    .map_ver    (map_ver)
  );

  function automatic int def_sel(int j);
    if (N_OUT == 1) return 0;
    return (j * (N_IN - 1) + (N_OUT - 1) / 2) / (N_OUT - 1);
  endfunction

  // Advances the model by one clock using the current inputs, then waits for
  // the edge and settles 1 time unit after it.
  task automatic cycle();
    int         n_act[N_OUT];
    int         n_shd[N_OUT];
    bit         n_act_inv[N_OUT];
    bit         n_shd_inv[N_OUT];
    int         n_ver;
    bit         n_busy;
    bit         n_err;
    logic [3:0] n_dout;
    bit         inv_in;
    inv_in = 1'b0;
`ifdef WIRE_ROUTER_INV_EN
    inv_in = cfg_inv;
`endif
    n_act = m_act; n_shd = m_shd; n_act_inv = m_act_inv; n_shd_inv = m_shd_inv;
    n_ver = m_ver; n_busy = 1'b0; n_err = 1'b0;
    for (int j = 0; j < N_OUT; j++) n_dout[j] = din[m_act[j]] ^ m_act_inv[j];
    if (rst) begin
      for (int j = 0; j < N_OUT; j++) begin
        n_act[j] = def_sel(j); n_shd[j] = def_sel(j);
        n_act_inv[j] = 1'b0; n_shd_inv[j] = 1'b0;
      end
      n_ver = 0; n_dout = '0;
    end else if (!m_busy) begin
      if (cfg_valid) begin
        if (int'(cfg_sel) < N_IN && int'(cfg_idx) < N_OUT) begin
          n_shd[cfg_idx] = cfg_sel;
          n_shd_inv[cfg_idx] = inv_in;
        end else begin
          n_err = 1'b1;
        end
      end
      if (cfg_commit) begin
        n_act = n_shd; n_act_inv = n_shd_inv;
        n_ver = (m_ver + 1) % 256;
        n_busy = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    m_act = n_act; m_shd = n_shd; m_act_inv = n_act_inv; m_shd_inv = n_shd_inv;
    m_ver = n_ver; m_busy = n_busy; m_err = n_err; m_dout = n_dout;
  endtask

  task automatic test_reset();
    rst = 1'b1; din = 3'b101;
    cycle();
    rst = 1'b0;
    checks++;
    if (dout !== 4'b0000) begin
      errors++; $display("FAIL reset_dout got %b want %b", dout, 4'b0000);
    end
    checks++;
    if (map_ver !== 8'd0 || cfg_ready !== 1'b1 || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got ver=%0d rdy=%b err=%b want 0 1 0", map_ver, cfg_ready, cfg_err);
    end
    cycle();
    checks++;
    if (dout !== 4'b1001) begin
      errors++; $display("FAIL default_map got %b want %b", dout, 4'b1001);
    end
  endtask

  task automatic test_commit();
    cfg_valid = 1'b1; cfg_idx = 2'd0; cfg_sel = 2'd2;
    cycle();
    cfg_idx = 2'd3; cfg_sel = 2'd0;
    cycle();
    cfg_valid = 1'b0; din = 3'b001;
    cycle();
    checks++;
    if (dout !== 4'b0001) begin
      errors++; $display("FAIL shadow_not_active got %b want %b", dout, 4'b0001);
    end
    cfg_commit = 1'b1;
    cycle();
    cfg_commit = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0 || map_ver !== 8'd1 || dout !== 4'b0001) begin
      errors++;
      $display("FAIL commit_edge got rdy=%b ver=%0d dout=%b want 0 1 0001", cfg_ready, map_ver, dout);
    end
    cycle();
    checks++;
    if (dout !== 4'b1000 || cfg_ready !== 1'b1) begin
      errors++; $display("FAIL new_map got dout=%b rdy=%b want 1000 1", dout, cfg_ready);
    end
  endtask

  task automatic test_reject();
    cfg_valid = 1'b1; cfg_idx = 2'd1; cfg_sel = 2'd3;
    cycle();
    cfg_valid = 1'b0;
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++; $display("FAIL err_pulse got %b want 1", cfg_err);
    end
    cycle();
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++; $display("FAIL err_clear got %b want 0", cfg_err);
    end
    cfg_commit = 1'b1;
    cycle();
    cfg_commit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      din = 3'($urandom);
      cycle();
      checks++;
      if (dout !== m_dout) begin
        errors++; $display("FAIL reject_keeps_map got %b want %b", dout, m_dout);
      end
    end
  endtask

  task automatic test_back_to_back();
    int ver_before;
    ver_before = m_ver;
    cfg_valid = 1'b1; cfg_idx = 2'd1; cfg_sel = 2'd2; cfg_commit = 1'b1;
    cycle();
    // Requests during the busy cycle must be dropped.
    cfg_idx = 2'd2; cfg_sel = 2'd0;
    cycle();
    cfg_valid = 1'b0; cfg_commit = 1'b0;
    checks++;
    if (int'(map_ver) != (ver_before + 1) % 256 || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL swap_ignored got ver=%0d err=%b want %0d 0", map_ver, cfg_err,
               (ver_before + 1) % 256);
    end
    din = 3'b100;
    cycle();
    // Map now w=c, x=c, y=b, z=a.
    checks++;
    if (dout !== 4'b0011) begin
      errors++; $display("FAIL same_cycle_write got %b want %b", dout, 4'b0011);
    end
    cfg_commit = 1'b1;
    cycle();
    cfg_commit = 1'b0;
    cycle();
    checks++;
    if (dout !== 4'b0011) begin
      errors++; $display("FAIL swap_write_dropped got %b want %b", dout, 4'b0011);
    end
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int k = 0; k < 255; k++) begin
      cfg_commit = 1'b1; cycle();
      cfg_commit = 1'b0; cycle();
    end
    checks++;
    if (map_ver !== 8'd255) begin
      errors++; $display("FAIL ver_255 got %0d want 255", map_ver);
    end
    cfg_commit = 1'b1; cycle();
    cfg_commit = 1'b0; cycle();
    checks++;
    if (map_ver !== 8'd0) begin
      errors++; $display("FAIL ver_wrap got %0d want 0", map_ver);
    end
  endtask

  task automatic test_reset_in_swap();
    cfg_valid = 1'b1; cfg_idx = 2'd0; cfg_sel = 2'd2; cfg_commit = 1'b1;
    cycle();
    cfg_valid = 1'b0; cfg_commit = 1'b0; rst = 1'b1; din = 3'b101;
    cycle();
    rst = 1'b0;
    checks++;
    if (map_ver !== 8'd0 || dout !== 4'b0000 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL swap_reset got ver=%0d dout=%b rdy=%b want 0 0000 1", map_ver, dout, cfg_ready);
    end
    cycle();
    checks++;
    if (dout !== 4'b1001) begin
      errors++; $display("FAIL swap_reset_map got %b want %b", dout, 4'b1001);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      din        = 3'($urandom);
      cfg_valid  = ($urandom_range(0, 2) == 0);
      cfg_idx    = 2'($urandom_range(0, 3));
      cfg_sel    = 2'($urandom_range(0, 3));
      cfg_commit = ($urandom_range(0, 4) == 0);
`ifdef WIRE_ROUTER_INV_EN
      cfg_inv    = 1'($urandom);
`endif
      rst        = ($urandom_range(0, 99) == 0);
      cycle();
      checks++;
      if (dout !== m_dout || cfg_ready !== !m_busy || cfg_err !== m_err ||
          int'(map_ver) != m_ver) begin
        errors++;
        $display("FAIL random[%0d] got dout=%b rdy=%b err=%b ver=%0d want %b %b %b %0d",
                 k, dout, cfg_ready, cfg_err, map_ver, m_dout, !m_busy, m_err, m_ver);
      end
    end
    rst = 1'b0; cfg_valid = 1'b0; cfg_commit = 1'b0;
    cycle();
  endtask

`ifdef WIRE_ROUTER_INV_EN
  task automatic test_invert();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cfg_valid = 1'b1; cfg_idx = 2'd0; cfg_sel = 2'd0; cfg_inv = 1'b1;
    cycle();
    cfg_valid = 1'b0; cfg_inv = 1'b0; cfg_commit = 1'b1;
    cycle();
    cfg_commit = 1'b0; din = 3'b000;
    cycle();
    checks++;
    if (dout !== 4'b0001) begin
      errors++; $display("FAIL invert got %b want %b", dout, 4'b0001);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_commit();
    test_reject();
    test_back_to_back();
    test_wrap();
    test_reset_in_swap();
`ifdef WIRE_ROUTER_INV_EN
    test_invert();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
